// File: rtl/cds_pkg.sv
// Shared types and constants for the CDS sample averager.
//   CDS_DATA_W / CDS_AVG_LOG2 : default sample width and averaging depth
//   ACC_W / RES_W             : accumulator and result widths for the defaults
//   PH_RST / PH_SIG           : phase tag encodings carried with each sample
//   state_e                   : averager FSM states
package cds_pkg;

  localparam int unsigned CDS_DATA_W   = 16;
  localparam int unsigned CDS_AVG_LOG2 = 2;
  localparam int unsigned ACC_W        = CDS_DATA_W + CDS_AVG_LOG2;
  localparam int unsigned RES_W        = CDS_DATA_W + 1;

  localparam logic PH_RST = 1'b0;
  localparam logic PH_SIG = 1'b1;

  typedef enum logic [1:0] {
    ST_ACC_RST = 2'd0,
    ST_ACC_SIG = 2'd1,
    ST_CALC    = 2'd2
  } state_e;

endpackage

// File: rtl/cds_sample_averager_if.sv
// Sample input and CDS result handshake between the ADC read stage,
// the averager and the downstream consumer.
//   adc_data_i/adc_valid_i/sample_sel_i : tagged sample strobe into the averager
//   cds_data_o/cds_valid_o/cds_ready_i  : signed result, valid/ready
// Modports: slave = averager, master = surrounding logic.
interface cds_sample_averager_if #(
  parameter int unsigned DATA_W = 16
);

  logic [DATA_W-1:0] adc_data_i;
  logic              adc_valid_i;
  logic              sample_sel_i;
  logic [DATA_W:0]   cds_data_o;
  logic              cds_valid_o;
  logic              cds_ready_i;

  modport slave (
    input  adc_data_i,
    input  adc_valid_i,
    input  sample_sel_i,
    input  cds_ready_i,
    output cds_data_o,
    output cds_valid_o
  );

  modport master (
    output adc_data_i,
    output adc_valid_i,
    output sample_sel_i,
    output cds_ready_i,
    input  cds_data_o,
    input  cds_valid_o
  );

endinterface

// File: rtl/cds_acc_unit.sv
// Clearable unsigned accumulator with add enable.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear, wins over add_i
//   add_i      : add data_i this cycle
//   data_i     : unsigned sample
//   acc_o      : registered running sum
module cds_acc_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [ACC_W-1:0] acc_q;

  // Running sum; width sized so 2^AVG_LOG2 full-scale samples cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= acc_q + ACC_W'(data_i);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cds_sample_averager.sv
// Averages 2^AVG_LOG2 reset-level and signal-level ADC samples and emits
// the signed CDS result (signal mean - reset mean, floored) on a
// valid/ready handshake.
//   clk_adc, rst_n : clock, async active-low reset
//   clear_i        : synchronous restart, also clears flags and pending result
//   bus            : sample input and result handshake (slave side)
//   seq_err_o      : sticky, wrong-phase sample or sample during CALC
//   ovf_o          : sticky, a result was dropped because the output was full
module cds_sample_averager
  import cds_pkg::*;
#(
  parameter int unsigned DATA_W   = CDS_DATA_W,
  parameter int unsigned AVG_LOG2 = CDS_AVG_LOG2
) (
  input  logic                  clk_adc,
  input  logic                  rst_n,
  input  logic                  clear_i,
  cds_sample_averager_if.slave  bus,
  output logic                  seq_err_o,
  output logic                  ovf_o
);

  localparam int unsigned ACC_BITS  = DATA_W + AVG_LOG2;
  localparam int unsigned RES_BITS  = DATA_W + 1;
  localparam int unsigned DIFF_BITS = ACC_BITS + 1;
  localparam int unsigned CNT_W     = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      acc_clr;
  logic                      acc_rst_en;
  logic                      acc_sig_en;
  logic                      load_res;
  logic                      drop_res;
  logic                      seq_err_set;
  logic [ACC_BITS-1:0]       acc_rst;
  logic [ACC_BITS-1:0]       acc_sig;
  logic signed [DIFF_BITS-1:0] diff_c;
  logic [RES_BITS-1:0]       res_c;
  logic [RES_BITS-1:0]       data_q;
  logic                      valid_q;
  logic                      seq_err_q;
  logic                      ovf_q;
  logic                      drain_c;

  cds_acc_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_BITS)
  ) u_acc_rst (
    .clk    (clk_adc),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .add_i  (acc_rst_en),
    .data_i (bus.adc_data_i),
    .acc_o  (acc_rst)
  );

  cds_acc_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_BITS)
  ) u_acc_sig (
    .clk    (clk_adc),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .add_i  (acc_sig_en),
    .data_i (bus.adc_data_i),
    .acc_o  (acc_sig)
  );

  // Sum difference, then arithmetic shift gives the floored mean difference;
  // |sum diff| < 2^ACC_BITS so the shifted value always fits RES_BITS.
  assign diff_c  = $signed({1'b0, acc_sig}) - $signed({1'b0, acc_rst});
  assign res_c   = RES_BITS'(diff_c >>> AVG_LOG2);
  assign drain_c = valid_q & bus.cds_ready_i;

  // State register.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_clr     = 1'b0;
    acc_rst_en  = 1'b0;
    acc_sig_en  = 1'b0;
    load_res    = 1'b0;
    drop_res    = 1'b0;
    seq_err_set = 1'b0;

    case (state_q)
      ST_ACC_RST: begin
        if (bus.adc_valid_i) begin
          if (bus.sample_sel_i == PH_RST) begin
            acc_rst_en = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_ACC_SIG;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            seq_err_set = 1'b1;
          end
        end
      end
      ST_ACC_SIG: begin
        if (bus.adc_valid_i) begin
          if (bus.sample_sel_i == PH_SIG) begin
            acc_sig_en = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_CALC;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            seq_err_set = 1'b1;
          end
        end
      end
      ST_CALC: begin
        // Output slot is free if empty or handing off this cycle.
        if (!valid_q || drain_c) begin
          load_res = 1'b1;
        end else begin
          drop_res = 1'b1;
        end
        acc_clr     = 1'b1;
        cnt_d       = '0;
        state_d     = ST_ACC_RST;
        seq_err_set = bus.adc_valid_i;
      end
      default: begin
        acc_clr = 1'b1;
        cnt_d   = '0;
        state_d = ST_ACC_RST;
      end
    endcase

    // Restart wins over everything, including a coincident sample.
    if (clear_i) begin
      state_d     = ST_ACC_RST;
      cnt_d       = '0;
      acc_clr     = 1'b1;
      acc_rst_en  = 1'b0;
      acc_sig_en  = 1'b0;
      load_res    = 1'b0;
      drop_res    = 1'b0;
      seq_err_set = 1'b0;
    end
  end

  // Output register and sticky flags.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (clear_i) begin
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (load_res) begin
        data_q  <= res_c;
        valid_q <= 1'b1;
      end else if (drain_c) begin
        valid_q <= 1'b0;
      end
      seq_err_q <= seq_err_q | seq_err_set;
      ovf_q     <= ovf_q | drop_res;
    end
  end

  assign bus.cds_data_o  = data_q;
  assign bus.cds_valid_o = valid_q;
  assign seq_err_o       = seq_err_q;
  assign ovf_o           = ovf_q;

endmodule

// File: tb/tb_cds_sample_averager.sv
// Directed test bench for cds_sample_averager (DATA_W=16, AVG_LOG2=2).
module tb_cds_sample_averager;

  logic clk_adc = 1'b0;
  logic rst_n;
  logic clear_i;
  logic seq_err_o;
  logic ovf_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_adc = ~clk_adc;

  cds_sample_averager_if #(.DATA_W(16)) bus();

  cds_sample_averager #(
    .DATA_W   (16),
    .AVG_LOG2 (2)
  ) dut (
    .clk_adc   (clk_adc),
    .rst_n     (rst_n),
    .clear_i   (clear_i),
    .bus       (bus),
    .seq_err_o (seq_err_o),
    .ovf_o     (ovf_o)
  );

  // Present one sample for one cycle, driven at the falling edge.
  task automatic put(input logic [15:0] d, input logic s);
    @(negedge clk_adc);
    bus.adc_valid_i  = 1'b1;
    bus.adc_data_i   = d;
    bus.sample_sel_i = s;
  endtask

  task automatic idle();
    @(negedge clk_adc);
    bus.adc_valid_i = 1'b0;
  endtask

  task automatic feed4(input logic [15:0] a, b, c, e, input logic s);
    put(a, s); put(b, s); put(c, s); put(e, s);
  endtask

  // Full reset+signal pair; returns at the falling edge inside CALC.
  task automatic pair(input logic [15:0] r0, r1, r2, r3,
                      input logic [15:0] s0, s1, s2, s3);
    feed4(r0, r1, r2, r3, 1'b0);
    feed4(s0, s1, s2, s3, 1'b1);
    idle();
  endtask

  task automatic wait_valid(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.cds_valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_adc);
    end
  endtask

  task automatic do_clear();
    @(negedge clk_adc);
    clear_i = 1'b1;
    @(negedge clk_adc);
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_adc);
    rst_n = 1'b1;
    @(negedge clk_adc);
    checks++;
    if (bus.cds_data_o !== 17'd0) begin
      errors++; $display("FAIL reset_data: got %h expected %h", bus.cds_data_o, 17'd0);
    end
    checks++;
    if (bus.cds_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.cds_valid_o);
    end
    checks++;
    if (seq_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_seq_err: got %b expected 0", seq_err_o);
    end
    checks++;
    if (ovf_o !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_o);
    end
  endtask

  task automatic test_basic();
    pair(16'd100, 16'd102, 16'd98, 16'd100, 16'd1100, 16'd1100, 16'd1100, 16'd1100);
    checks++;
    if (bus.cds_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_calc_valid: got %b expected 0", bus.cds_valid_o);
    end
    @(negedge clk_adc);
    checks++;
    if (bus.cds_valid_o !== 1'b1) begin
      errors++; $display("FAIL basic_latency_valid: got %b expected 1", bus.cds_valid_o);
    end
    checks++;
    if (bus.cds_data_o !== 17'd1000) begin
      errors++; $display("FAIL basic_data: got %0d expected 1000", bus.cds_data_o);
    end
    @(negedge clk_adc);
    checks++;
    if (bus.cds_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle: got %b expected 0", bus.cds_valid_o);
    end
    checks++;
    if ({seq_err_o, ovf_o} !== 2'b00) begin
      errors++; $display("FAIL basic_flags: got %b expected 00", {seq_err_o, ovf_o});
    end
  endtask

  task automatic test_signed();
    logic seen;
    pair(16'd100, 16'd100, 16'd100, 16'd100, 16'd50, 16'd50, 16'd50, 16'd50);
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'h1FFCE) begin
      errors++; $display("FAIL negative: seen=%b got %h expected 1ffce", seen, bus.cds_data_o);
    end
    pair(16'd100, 16'd101, 16'd101, 16'd101, 16'd100, 16'd100, 16'd100, 16'd100);
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'h1FFFF) begin
      errors++; $display("FAIL floor: seen=%b got %h expected 1ffff", seen, bus.cds_data_o);
    end
    pair(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0);
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'h10001) begin
      errors++; $display("FAIL extreme_neg: seen=%b got %h expected 10001", seen, bus.cds_data_o);
    end
    pair(16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'h0FFFF) begin
      errors++; $display("FAIL extreme_pos: seen=%b got %h expected 0ffff", seen, bus.cds_data_o);
    end
    @(negedge clk_adc);
  endtask

  task automatic test_back_to_back();
    logic seen;
    bus.cds_ready_i = 1'b0;
    pair(16'd100, 16'd102, 16'd98, 16'd100, 16'd1100, 16'd1100, 16'd1100, 16'd1100);
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'd1000) begin
      errors++; $display("FAIL bp_first: seen=%b got %0d expected 1000", seen, bus.cds_data_o);
    end
    pair(16'd0, 16'd0, 16'd0, 16'd0, 16'd500, 16'd500, 16'd500, 16'd500);
    @(negedge clk_adc);
    checks++;
    if (ovf_o !== 1'b1) begin
      errors++; $display("FAIL bp_ovf: got %b expected 1", ovf_o);
    end
    checks++;
    if (bus.cds_valid_o !== 1'b1 || bus.cds_data_o !== 17'd1000) begin
      errors++; $display("FAIL bp_hold: valid=%b got %0d expected 1000", bus.cds_valid_o, bus.cds_data_o);
    end
    bus.cds_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.cds_data_o !== 17'd1000) begin
      errors++; $display("FAIL bp_release_data: got %0d expected 1000", bus.cds_data_o);
    end
    @(negedge clk_adc);
    checks++;
    if (bus.cds_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_single_transfer: got %b expected 0", bus.cds_valid_o);
    end
    do_clear();
    checks++;
    if (ovf_o !== 1'b0) begin
      errors++; $display("FAIL bp_clear_ovf: got %b expected 0", ovf_o);
    end
  endtask

  task automatic test_seq_err();
    logic seen;
    put(16'd100, 1'b0);
    put(16'd102, 1'b0);
    put(16'd9999, 1'b1);
    put(16'd98, 1'b0);
    put(16'd100, 1'b0);
    feed4(16'd1100, 16'd1100, 16'd1100, 16'd1100, 1'b1);
    idle();
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'd1000) begin
      errors++; $display("FAIL seq_excluded: seen=%b got %0d expected 1000", seen, bus.cds_data_o);
    end
    checks++;
    if (seq_err_o !== 1'b1) begin
      errors++; $display("FAIL seq_wrong_phase: got %b expected 1", seq_err_o);
    end
    do_clear();
    checks++;
    if (seq_err_o !== 1'b0) begin
      errors++; $display("FAIL seq_clear: got %b expected 0", seq_err_o);
    end
    // Extra sample lands in the CALC cycle.
    feed4(16'd100, 16'd102, 16'd98, 16'd100, 1'b0);
    feed4(16'd1100, 16'd1100, 16'd1100, 16'd1100, 1'b1);
    put(16'd5000, 1'b0);
    idle();
    checks++;
    if (seq_err_o !== 1'b1) begin
      errors++; $display("FAIL seq_calc_sample: got %b expected 1", seq_err_o);
    end
    checks++;
    if (bus.cds_valid_o !== 1'b1 || bus.cds_data_o !== 17'd1000) begin
      errors++; $display("FAIL seq_calc_result: valid=%b got %0d expected 1000", bus.cds_valid_o, bus.cds_data_o);
    end
    pair(16'd100, 16'd102, 16'd98, 16'd100, 16'd1100, 16'd1100, 16'd1100, 16'd1100);
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'd1000) begin
      errors++; $display("FAIL seq_calc_discarded: seen=%b got %0d expected 1000", seen, bus.cds_data_o);
    end
    @(negedge clk_adc);
  endtask

  task automatic test_rst_mid();
    logic seen;
    put(16'd100, 1'b0);
    put(16'd102, 1'b0);
    put(16'd7, 1'b1);
    idle();
    rst_n = 1'b0;
    @(negedge clk_adc);
    rst_n = 1'b1;
    checks++;
    if ({seq_err_o, ovf_o, bus.cds_valid_o} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_flags: got %b expected 000", {seq_err_o, ovf_o, bus.cds_valid_o});
    end
    pair(16'd100, 16'd102, 16'd98, 16'd100, 16'd1100, 16'd1100, 16'd1100, 16'd1100);
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'd1000 || seq_err_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_result: seen=%b got %0d seq=%b expected 1000 seq=0", seen, bus.cds_data_o, seq_err_o);
    end
    @(negedge clk_adc);
  endtask

  task automatic test_clear_mid();
    logic seen;
    put(16'd100, 1'b0);
    put(16'd102, 1'b0);
    // Clear together with a wrong-phase sample: no error expected.
    @(negedge clk_adc);
    clear_i          = 1'b1;
    bus.adc_valid_i  = 1'b1;
    bus.adc_data_i   = 16'd9999;
    bus.sample_sel_i = 1'b1;
    @(negedge clk_adc);
    clear_i         = 1'b0;
    bus.adc_valid_i = 1'b0;
    checks++;
    if ({seq_err_o, ovf_o, bus.cds_valid_o} !== 3'b000) begin
      errors++; $display("FAIL clear_mid_flags: got %b expected 000", {seq_err_o, ovf_o, bus.cds_valid_o});
    end
    pair(16'd100, 16'd102, 16'd98, 16'd100, 16'd1100, 16'd1100, 16'd1100, 16'd1100);
    wait_valid(seen);
    checks++;
    if (seen !== 1'b1 || bus.cds_data_o !== 17'd1000 || seq_err_o !== 1'b0) begin
      errors++; $display("FAIL clear_mid_result: seen=%b got %0d seq=%b expected 1000 seq=0", seen, bus.cds_data_o, seq_err_o);
    end
    @(negedge clk_adc);
  endtask

  initial begin
    clear_i          = 1'b0;
    bus.adc_valid_i  = 1'b0;
    bus.adc_data_i   = '0;
    bus.sample_sel_i = 1'b0;
    bus.cds_ready_i  = 1'b1;
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_seq_err();
    test_rst_mid();
    test_clear_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
